// File: rtl/fwrd_unit_if.sv
// Source-operand lookup path between reg_read and the forwarding buffer.
// reg_read drives the two source tags; the forwarding buffer returns a hit flag and value for each.
interface fwrd_reg_read_if #(
    parameter int NUM_PREGS = 64,
    localparam int PW = $clog2(NUM_PREGS)
);
    logic [PW-1:0] src1_reg;
    logic [PW-1:0] src2_reg;
    logic          src1_fwrd_hit;
    logic [31:0]   src1_val;
    logic          src2_fwrd_hit;
    logic [31:0]   src2_val;

    modport fwrd_unit (
        input  src1_reg, src2_reg,
        output src1_fwrd_hit, src1_val, src2_fwrd_hit, src2_val
    );

    modport reg_read (
        output src1_reg, src2_reg,
        input  src1_fwrd_hit, src1_val, src2_fwrd_hit, src2_val
    );
endinterface

// File: rtl/fwrd_unit.sv
// Result-forwarding buffer: holds each writeback broadcast for FWD_DEPTH cycles, newest value wins.
// Latency: 0-cycle combinational lookup; no handshake, never stalls.
module fwrd_unit #(
    parameter int NUM_PREGS     = 64,
    parameter int NUM_WB_PORTS  = 2,
    parameter int FWD_DEPTH     = 3,
    parameter bit ASSERT_WB_DUP = 1'b1,
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [NUM_WB_PORTS-1:0]            wb_valid,
    input  logic [NUM_WB_PORTS-1:0][PW-1:0]    wb_preg,
    input  logic [NUM_WB_PORTS-1:0][31:0]      wb_data,
    fwrd_reg_read_if.fwrd_unit                 fwrd
);

    logic [FWD_DEPTH-1:0][NUM_WB_PORTS-1:0]           vld_q,  vld_d;
    logic [FWD_DEPTH-1:0][NUM_WB_PORTS-1:0][PW-1:0]   preg_q, preg_d;
    logic [FWD_DEPTH-1:0][NUM_WB_PORTS-1:0][31:0]     data_q, data_d;

    logic [1:0][PW-1:0] src_tag;
    logic [1:0]         hit;
    logic [1:0][31:0]   val;
    logic               wb_dup;

    // Writes to preg 0 are dropped here so the lookup never needs to special-case stored entries.
    always_comb begin
        vld_d  = '0;
        preg_d = preg_q;
        data_d = data_q;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            vld_d[0][p]  = wb_valid[p] && (wb_preg[p] != '0) && !flush;
            preg_d[0][p] = wb_preg[p];
            data_d[0][p] = wb_data[p];
        end
        for (int k = 1; k < FWD_DEPTH; k++) begin
            vld_d[k]  = flush ? '0 : vld_q[k-1];
            preg_d[k] = preg_q[k-1];
            data_d[k] = data_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        preg_q <= preg_d;
        data_q <= data_d;
    end

    // Scan oldest to newest and let each later match overwrite, so the newest/lowest-port match sticks.
    always_comb begin
        src_tag[0] = fwrd.src1_reg;
        src_tag[1] = fwrd.src2_reg;
        hit        = '0;
        val        = '0;
        for (int s = 0; s < 2; s++) begin
            if (!flush && (src_tag[s] != '0)) begin
                for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                    for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
                        if (vld_q[k][p] && (preg_q[k][p] == src_tag[s])) begin
                            hit[s] = 1'b1;
                            val[s] = data_q[k][p];
                        end
                    end
                end
                for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_valid[p] && (wb_preg[p] == src_tag[s])) begin
                        hit[s] = 1'b1;
                        val[s] = wb_data[p];
                    end
                end
            end
        end
    end

    assign fwrd.src1_fwrd_hit = hit[0];
    assign fwrd.src1_val      = val[0];
    assign fwrd.src2_fwrd_hit = hit[1];
    assign fwrd.src2_val      = val[1];

    // Two ports writing the same live preg in one cycle is an upstream bug; preg 0 writes are harmless.
    always_comb begin
        wb_dup = 1'b0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            for (int q = p + 1; q < NUM_WB_PORTS; q++) begin
                if (wb_valid[p] && wb_valid[q] && (wb_preg[p] == wb_preg[q]) && (wb_preg[p] != '0)) begin
                    wb_dup = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ASSERT_WB_DUP && rst_n) begin
            assert (!wb_dup) else $error("fwrd_unit: two writeback ports target the same preg");
        end
    end

endmodule
